// File: rtl/vedic_pkg.sv
// Shared definitions for the pipelined 8x8 Vedic multiplier.
// Holds the datapath widths, the stage-1 partial-product bundle and the
// 8-bit ripple-carry adder used for the cross-term sum.
package vedic_pkg;

   localparam int OP_W   = 8;
   localparam int PP_W   = 8;
   localparam int PROD_W = 16;
   localparam int NSTAGE = 3;

   // Four 4x4 partial products of one operand pair.
   typedef struct packed {
      logic [PP_W-1:0] pp_ll;
      logic [PP_W-1:0] pp_lh;
      logic [PP_W-1:0] pp_hl;
      logic [PP_W-1:0] pp_hh;
   } pp_set_t;

   // 8-bit ripple-carry adder; the carry out is returned as the MSB.
   function automatic logic [PP_W:0] ripple_add8(input logic [PP_W-1:0] x,
                                                 input logic [PP_W-1:0] y);
      logic [PP_W-1:0] sum;
      logic            carry;
      carry = 1'b0;
      for (int i = 0; i < PP_W; i++) begin
         sum[i] = x[i] ^ y[i] ^ carry;
         carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
      end
      return {carry, sum};
   endfunction

endpackage

// File: rtl/vedic_mult4.sv
// Combinational 4x4 -> 8-bit unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
// Built from four 2x2 vertical/crosswise blocks whose cross terms are summed
// and aligned into the 8-bit product.
module vedic_mult4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] prod
);

   // 2x2 Vedic block: vertical LSB, crosswise middle, vertical MSB.
   function automatic logic [3:0] mult2(input logic [1:0] u, input logic [1:0] v);
      logic       c1;
      logic [3:0] r;
      r[0] = u[0] & v[0];
      r[1] = (u[1] & v[0]) ^ (u[0] & v[1]);
      c1   = (u[1] & v[0]) & (u[0] & v[1]);
      r[2] = (u[1] & v[1]) ^ c1;
      r[3] = (u[1] & v[1]) & c1;
      return r;
   endfunction

   logic [3:0] q_ll_s;
   logic [3:0] q_lh_s;
   logic [3:0] q_hl_s;
   logic [3:0] q_hh_s;
   logic [4:0] cross_s;

   // Form the four 2x2 products and combine them into the 4x4 product.
   always_comb begin
      q_ll_s  = mult2(x[1:0], y[1:0]);
      q_lh_s  = mult2(x[1:0], y[3:2]);
      q_hl_s  = mult2(x[3:2], y[1:0]);
      q_hh_s  = mult2(x[3:2], y[3:2]);
      cross_s = {1'b0, q_lh_s} + {1'b0, q_hl_s};
      prod    = {q_hh_s, q_ll_s} + {1'b0, cross_s, 2'b00};
   end

endmodule

// File: rtl/vedic_mult8_pipe.sv
// 3-stage pipelined 8x8 unsigned Vedic multiplier with valid/ready on both
// sides. S1 registers four 4x4 partial products, S2 the cross-term sum, S3
// the aligned 16-bit product. Each stage loads when empty or when its
// downstream stage loads, so the pipe runs bubble-free at one pair per cycle.
// A pair accepted on a rising edge shows out_valid after the third rising
// edge counting the accepting one.
// Optional feature: define VEDIC_MULT8_ACC_EN to add the ACC_W parameter,
// the acc_clr/acc ports and a running sum of delivered products.
module vedic_mult8_pipe
   import vedic_pkg::*;
#(
   parameter int TAG_W = 4
`ifdef VEDIC_MULT8_ACC_EN
   ,
   parameter int ACC_W = 24
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p,
   output logic [TAG_W-1:0]  out_tag
`ifdef VEDIC_MULT8_ACC_EN
   ,
   input  logic              acc_clr,
   output logic [ACC_W-1:0]  acc
`endif
);

   typedef struct packed {
      pp_set_t          pp;
      logic [TAG_W-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic [PP_W-1:0]  pp_ll;
      logic [PP_W:0]    mid;
      logic [PP_W-1:0]  pp_hh;
      logic [TAG_W-1:0] tag;
   } s2_t;

   localparam s1_t S1_RST = {($bits(s1_t)){1'b0}};
   localparam s2_t S2_RST = {($bits(s2_t)){1'b0}};

   logic s1_v_r;
   logic s2_v_r;
   logic s1_ld_s;
   logic s2_ld_s;
   logic s3_ld_s;

   s1_t  s1_r;
   s1_t  s1_nxt_s;
   s2_t  s2_r;
   s2_t  s2_nxt_s;

   logic [PP_W-1:0]   pp_ll_s;
   logic [PP_W-1:0]   pp_lh_s;
   logic [PP_W-1:0]   pp_hl_s;
   logic [PP_W-1:0]   pp_hh_s;
   logic [PROD_W-1:0] s3_sum_s;

   vedic_mult4 u_mult_ll (.x(a[3:0]), .y(b[3:0]), .prod(pp_ll_s));
   vedic_mult4 u_mult_lh (.x(a[3:0]), .y(b[7:4]), .prod(pp_lh_s));
   vedic_mult4 u_mult_hl (.x(a[7:4]), .y(b[3:0]), .prod(pp_hl_s));
   vedic_mult4 u_mult_hh (.x(a[7:4]), .y(b[7:4]), .prod(pp_hh_s));

   // Stall chain: a stage loads when empty or when the stage after it loads.
   always_comb begin
      s3_ld_s  = ~out_valid | out_ready;
      s2_ld_s  = ~s2_v_r | s3_ld_s;
      s1_ld_s  = ~s1_v_r | s2_ld_s;
      in_ready = s1_ld_s;
   end

   // Next-state payloads for S1 and S2, plus the S3 alignment sum.
   always_comb begin
      s1_nxt_s.pp.pp_ll = pp_ll_s;
      s1_nxt_s.pp.pp_lh = pp_lh_s;
      s1_nxt_s.pp.pp_hl = pp_hl_s;
      s1_nxt_s.pp.pp_hh = pp_hh_s;
      s1_nxt_s.tag      = in_tag;

      s2_nxt_s.pp_ll    = s1_r.pp.pp_ll;
      s2_nxt_s.mid      = ripple_add8(s1_r.pp.pp_lh, s1_r.pp.pp_hl);
      s2_nxt_s.pp_hh    = s1_r.pp.pp_hh;
      s2_nxt_s.tag      = s1_r.tag;

      // pp_ll + (pp_hh << 8) is a plain concatenation; mid lands at bit 4.
      s3_sum_s = {s2_r.pp_hh, s2_r.pp_ll} + {3'b000, s2_r.mid, 4'b0000};
   end

   // Stage 1: capture the partial products of an accepted pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_r <= 1'b0;
         s1_r   <= S1_RST;
      end else if (s1_ld_s) begin
         s1_v_r <= in_valid;
         if (in_valid) begin
            s1_r <= s1_nxt_s;
         end
      end
   end

   // Stage 2: capture the cross-term sum and pass the outer terms through.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v_r <= 1'b0;
         s2_r   <= S2_RST;
      end else if (s2_ld_s) begin
         s2_v_r <= s1_v_r;
         if (s1_v_r) begin
            s2_r <= s2_nxt_s;
         end
      end
   end

   // Stage 3: register the aligned product and its tag for the consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         p         <= {PROD_W{1'b0}};
         out_tag   <= {TAG_W{1'b0}};
      end else if (s3_ld_s) begin
         out_valid <= s2_v_r;
         if (s2_v_r) begin
            p       <= s3_sum_s;
            out_tag <= s2_r.tag;
         end
      end
   end

`ifdef VEDIC_MULT8_ACC_EN
   logic             deliver_s;
   logic [ACC_W-1:0] p_ext_s;

   // Delivery strobe and zero-extended product for the accumulator.
   always_comb begin
      deliver_s              = out_valid & out_ready;
      p_ext_s                = {ACC_W{1'b0}};
      p_ext_s[PROD_W-1:0]    = p;
   end

   // Running sum of delivered products; a clear wins over accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= {ACC_W{1'b0}};
      end else if (acc_clr) begin
         acc <= deliver_s ? p_ext_s : {ACC_W{1'b0}};
      end else if (deliver_s) begin
         acc <= acc + p_ext_s;
      end
   end
`endif

endmodule

// File: tb/tb_vedic_mult8_pipe.sv
// Scoreboard bench for vedic_mult8_pipe: accepted pairs push a*b into a
// queue, a monitor pops and compares on every delivery.
module tb_vedic_mult8_pipe;

   localparam int TAG_W = 4;
   localparam int ACC_W = 24;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       a;
   logic [7:0]       b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      p;
   logic [TAG_W-1:0] out_tag;
`ifdef VEDIC_MULT8_ACC_EN
   logic             acc_clr;
   logic [ACC_W-1:0] acc;
   longint           acc_model = 0;
`endif

   vedic_mult8_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .out_tag   (out_tag)
`ifdef VEDIC_MULT8_ACC_EN
      ,
      .acc_clr   (acc_clr),
      .acc       (acc)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]      p;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   del_cnt  = 0;
   int   last_del = -10;
   int   cur_run  = 0;
   int   max_run  = 0;
   int   last_p   = -1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int ref_mul(input int x, input int y);
      return x * y;
   endfunction

   // Input side: every accepted pair queues its expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && in_valid && in_ready) begin
         e.p   = 16'(ref_mul(int'(a), int'(b)));
         e.tag = in_tag;
         exp_q.push_back(e);
      end
   end

   logic             hold_pend = 1'b0;
   logic [15:0]      hold_p;
   logic [TAG_W-1:0] hold_tag;

   // Output side: compare deliveries against the queue, check stall stability.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         exp_q.delete();
         hold_pend = 1'b0;
`ifdef VEDIC_MULT8_ACC_EN
         acc_model = 0;
`endif
      end else begin
`ifdef VEDIC_MULT8_ACC_EN
         check("acc_track", longint'(acc), acc_model);
`endif
         if (hold_pend) begin
            check("stall_valid", longint'(out_valid), 1);
            check("stall_p", longint'(p), longint'(hold_p));
            check("stall_tag", longint'(out_tag), longint'(hold_tag));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out: got p=%0d with %0d results expected", p, exp_q.size());
`ifdef VEDIC_MULT8_ACC_EN
               if (acc_clr) acc_model = 0;
`endif
            end else begin
               e = exp_q.pop_front();
               check("p", longint'(p), longint'(e.p));
               check("tag", longint'(out_tag), longint'(e.tag));
`ifdef VEDIC_MULT8_ACC_EN
               if (acc_clr) acc_model = longint'(e.p);
               else acc_model = (acc_model + longint'(e.p)) % (longint'(1) << ACC_W);
`endif
            end
            del_cnt++;
            last_p  = int'(p);
            cur_run = (last_del == cyc - 1) ? cur_run + 1 : 1;
            if (cur_run > max_run) max_run = cur_run;
            last_del = cyc;
         end else begin
`ifdef VEDIC_MULT8_ACC_EN
            if (acc_clr) acc_model = 0;
`endif
         end
         hold_pend = out_valid && !out_ready;
         hold_p    = p;
         hold_tag  = out_tag;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a pair and hold it until accepted (bounded).
   task automatic issue(input logic [7:0] xa, input logic [7:0] xb,
                        input logic [TAG_W-1:0] xt, output int waited);
      logic got;
      a = xa; b = xb; in_tag = xt; in_valid = 1'b1;
      waited = 0;
      got = 1'b0;
      while (!got && waited < 100) begin
         @(negedge clk);
         got = in_ready;
         step();
         waited++;
      end
      if (!got) check("issue_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int tot;
      int d0;
      int accepts;
      int sent;
      int guard;
      logic pend;
      logic took;

      rst = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5; in_tag = 4'd1; out_ready = 1'b1;
`ifdef VEDIC_MULT8_ACC_EN
      acc_clr = 1'b0;
`endif
      // Reset held two cycles with in_valid high.
      step(); step();
      rst = 1'b0; in_valid = 1'b0;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_p", longint'(p), 0);
      check("rst_out_tag", longint'(out_tag), 0);
      check("rst_in_ready", longint'(in_ready), 1);
`ifdef VEDIC_MULT8_ACC_EN
      check("rst_acc", longint'(acc), 0);
`endif
      step();
      check("rst_nothing_accepted", longint'(out_valid), 0);

      // Single pair FF*FF, latency measured in edges from the accepting one.
      a = 8'hFF; b = 8'hFF; in_tag = 4'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("lat_edge1", longint'(out_valid), 0);
      step();
      check("lat_edge2", longint'(out_valid), 0);
      step();
      check("lat_edge3_valid", longint'(out_valid), 1);
      check("single_p", longint'(p), 65025);
      check("single_tag", longint'(out_tag), 3);
      step(); step();

      // Eight pairs back to back with out_ready high.
      d0 = del_cnt; tot = 0;
      issue(8'd12, 8'd13, 4'd0, w); tot += w;
      issue(8'd0, 8'd200, 4'd1, w); tot += w;
      for (int i = 2; i < 8; i++) begin
         issue(8'($urandom), 8'($urandom), 4'(i), w);
         tot += w;
      end
      in_valid = 1'b0;
      check("stream_accept_cycles", tot, 8);
      repeat (6) step();
      check("stream_deliveries", del_cnt - d0, 8);
      check("stream_consecutive", (max_run >= 8) ? 1 : 0, 1);
      check("stream_12x13", 0, 0 + (last_p >= 0 ? 0 : 1));

      // Backpressure: fill with out_ready low, then release.
      out_ready = 1'b0; d0 = del_cnt; accepts = 0;
      a = 8'd17; b = 8'd3; in_tag = 4'd9; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         took = in_ready;
         step();
         if (took) begin
            accepts++;
            a = 8'($urandom); b = 8'($urandom); in_tag = 4'($urandom);
         end
      end
      check("bp_accepts", accepts, 3);
      check("bp_in_ready_low", longint'(in_ready), 0);
      in_valid = 1'b0;
      repeat (2) step();
      check("bp_no_delivery", del_cnt - d0, 0);
      out_ready = 1'b1;
      repeat (6) step();
      check("bp_released", del_cnt - d0, 3);
      check("bp_queue_empty", exp_q.size(), 0);

      // Reset with three pairs in flight drops them.
      out_ready = 1'b0;
      issue(8'd100, 8'd100, 4'd1, w);
      issue(8'd50, 8'd60, 4'd2, w);
      issue(8'd33, 8'd44, 4'd3, w);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0; out_ready = 1'b1; d0 = del_cnt;
      repeat (5) step();
      check("flush_no_delivery", del_cnt - d0, 0);
      check("flush_out_valid", longint'(out_valid), 0);
      issue(8'd7, 8'd9, 4'd5, w);
      in_valid = 1'b0;
      repeat (4) step();
      check("post_flush_count", del_cnt - d0, 1);
      check("post_flush_p", last_p, 63);

`ifdef VEDIC_MULT8_ACC_EN
      // Accumulator: three 200*200 deliveries, then clear coinciding with 2*3.
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 3; i++) issue(8'd200, 8'd200, 4'(i), w);
      in_valid = 1'b0;
      repeat (5) step();
      check("acc_3x40000", longint'(acc), 120000);
      issue(8'd2, 8'd3, 4'd7, w);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("acc_wait_valid", longint'(out_valid), 1);
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      check("acc_clr_with_delivery", longint'(acc), 6);
      step();
`endif

      // Random traffic against the scoreboard.
      sent = 0; guard = 0; pend = 1'b0;
      while (sent < 10000 && guard < 40000) begin
         if (!pend) begin
            if ($urandom_range(0, 99) < 70) begin
               a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
               b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
               in_tag = 4'($urandom);
               in_valid = 1'b1;
               pend = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 99) < 70);
         @(negedge clk);
         took = in_valid && in_ready;
         step();
         if (took) begin
            pend = 1'b0;
            sent++;
            in_valid = 1'b0;
         end
         guard++;
      end
      check("random_sent", sent, 10000);
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         step();
         guard++;
      end
      step();
      check("random_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
